expression_stack: RTL
=====================

# expression_stack

Data-holding expression stack that sits directly downstream of `controlUnit` in the multicycle stack processor. It executes the stack-control word (`ESAct`, `ESOp`, `popAmt`, `dupNum`, `flip`) on the cycle's rising edge. It exposes the top two entries to the ALU operand muxes and the store path. Push data arrives already selected by the `PushSrc` mux in the datapath.

## Interface
- `WIDTH`, 16, data word width
- `DEPTH`, 16, number of entries (power of two, ≥4)

- `CLK`  in  1  clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `ESAct`  in  1  stack operation enable for this cycle
- `ESOp`  in  2  00 PUSH, 01 POP, 10 DUP, 11 REPL (pop then push)
- `popAmt`  in  1  0 → remove 1 entry, 1 → remove 2 (POP/REPL)
- `dupNum`  in  2  DUP source depth: 0 = top … 3 = fourth entry
- `flip`  in  1  swap top two entries; overrides `ESOp` when `ESAct`=1
- `pushData`  in  WIDTH  value for PUSH/REPL
- `errClr`  in  1  clears sticky error flags
- `top`  out  WIDTH  entry at depth 0, 0 when empty
- `second`  out  WIDTH  entry at depth 1, 0 when count<2
- `count`  out  $clog2(DEPTH)+1  valid entries
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `ovf`  out  1  sticky overflow
- `unf`  out  1  sticky underflow

## Operation
- `ESAct`=0: no change, regardless of other inputs.
- flip (count≥2): swap depth 0 and 1; count unchanged.
- PUSH (count<DEPTH): new top = `pushData`; count+1.
- POP (count ≥ n, n = popAmt+1): count−n; contents below untouched.
- DUP (count > dupNum, count<DEPTH): new top = old entry at depth `dupNum`; count+1.
- REPL (count ≥ n): remove n, then push `pushData`; net count −popAmt. Used for ALU writeback. Never overflows.
- Illegal op is fully suppressed: no storage, count or pointer change.
  - PUSH/DUP when full → `ovf`.
  - POP/REPL/DUP/flip with insufficient entries → `unf`.
  - DUP when full and dupNum ≥ count → both flags set.
- Sticky flags hold until `errClr` or reset. When `errClr` and a new error occur in the same cycle, the flag ends set.
- Storage is a circular register array indexed by a `$clog2(DEPTH)`-bit top pointer; wrap-around at DEPTH−1 → 0 is transparent.
- Reset (any time, including mid-instruction) asserts immediately:
  - count=0, pointer=0, `ovf`=`unf`=0, `empty`=1, `full`=0, `top`=`second`=0.
  - Array contents are not cleared.

## Timing
- All state updates on rising `CLK`. `top`, `second`, `count`, `full`, `empty` are combinational from registered state. The effect of an operation is visible in the cycle after the edge, so one-cycle latency.
- No handshake. `controlUnit` guarantees at most one `ESAct` cycle per state; the block accepts back-to-back operations every cycle.
- Inputs must be stable a setup time before the edge. Output settling is a combinational read of array plus pointer.
- Error flags rise in the cycle after the offending edge.

## Configuration
- `EXPR_STACK_STATUS_EN` defined: `ovf`/`unf` sticky logic and `errClr` are built as specified.
- `EXPR_STACK_STATUS_EN` undefined:
  - `ovf` and `unf` are tied 0 and `errClr` is ignored.
  - Illegal operations are still suppressed identically.
  - Port list is unchanged.

## Structure
- Shared package `stack_pkg` holds:
  - `ESOp` encodings (`ES_PUSH`, `ES_POP`, `ES_DUP`, `ES_REPL`)
  - default `WIDTH`/`DEPTH`
  - The same constants are used by `controlUnit`.
- One sub-module, `es_regfile`: DEPTH×WIDTH array with one write port and three read ports (depth 0, depth 1, depth `dupNum`), addressed relative to the pointer.
- Legality checks, pointer/count arithmetic and flags stay in `expression_stack`.

## Test plan
- Reset low mid-run with count=5 → count=0, `empty`=1, `top`=0, flags 0 without a clock edge.
- Push 0x0011, 0x0022, 0x0033 → `top`=0x0033, `second`=0x0022, count=3. Then flip → `top`=0x0022, `second`=0x0033.
- Stack [0x0033, 0x0022, 0x0011]: REPL popAmt=1, pushData=0x0055 → count=2, `top`=0x0055, `second`=0x0011.
- DUP dupNum=2 with count=3 (top first: A, B, C) → `top`=C, count=4. DUP dupNum=3 with count=3 → no change, `unf`=1.
- Fill to DEPTH (16) and push 0xBEEF:
  - `full`=1, count stays 16, `top` unchanged, `ovf`=1.
  - 20 pop/push cycles exercise pointer wrap with correct data.
- POP popAmt=1 with count=1 → `unf`=1, count=1. `errClr` → `unf`=0. Without `EXPR_STACK_STATUS_EN` the flags stay 0 but the op is still suppressed.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared expression stack op encodings and default sizes
package stack_pkg;

    localparam int ES_WIDTH_DEF = 16;
    localparam int ES_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ES_PUSH = 2'b00,
        ES_POP  = 2'b01,
        ES_DUP  = 2'b10,
        ES_REPL = 2'b11
    } es_op_t;

endpackage

// File: rtl/es_regfile.sv
// rtl/es_regfile.sv - circular stack storage, one write port, reads at depth 0/1/dup relative to pointer
module es_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic [$clog2(DEPTH)-1:0]   ptr,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       swap_en,
    input  logic [1:0]                 dup_num,
    output logic [WIDTH-1:0]           top_data,
    output logic [WIDTH-1:0]           second_data,
    output logic [WIDTH-1:0]           dup_data
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    second_idx;
    logic [PW-1:0]    dup_idx;

    // ptr names the next free slot, so depth d lives at ptr-1-d; modulo
    // arithmetic on PW bits makes the wrap transparent.
    assign top_idx    = ptr - PW'(1);
    assign second_idx = ptr - PW'(2);
    assign dup_idx    = ptr - PW'(1) - PW'(dup_num);

    assign top_data    = mem[top_idx];
    assign second_data = mem[second_idx];
    assign dup_data    = mem[dup_idx];

    // Storage update: swap the top pair for flip, otherwise the single write port.
    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (swap_en) begin
            mem[top_idx]    <= mem[second_idx];
            mem[second_idx] <= mem[top_idx];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/expression_stack.sv
// rtl/expression_stack.sv - expression stack top: legality, pointer/count, sticky flags (EXPR_STACK_STATUS_EN)
module expression_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = ES_WIDTH_DEF,
    parameter int DEPTH = ES_DEPTH_DEF
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     ESAct,
    input  logic [1:0]               ESOp,
    input  logic                     popAmt,
    input  logic [1:0]               dupNum,
    input  logic                     flip,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     errClr,
    output logic [WIDTH-1:0]         top,
    output logic [WIDTH-1:0]         second,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             swap_en;
    logic             ovf_evt;
    logic             unf_evt;
    logic [WIDTH-1:0] top_data;
    logic [WIDTH-1:0] second_data;
    logic [WIDTH-1:0] dup_data;
    logic             full_w;
    logic [CW-1:0]    n_pop;
    logic [PW-1:0]    n_ptr;
    logic [CW-1:0]    dup_cnt;

    es_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk         (CLK),
        .ptr         (ptr_q),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_en     (swap_en),
        .dup_num     (dupNum),
        .top_data    (top_data),
        .second_data (second_data),
        .dup_data    (dup_data)
    );

    assign full_w  = (count_q == CW'(DEPTH));
    assign n_pop   = popAmt ? CW'(2) : CW'(1);
    assign n_ptr   = popAmt ? PW'(2) : PW'(1);
    assign dup_cnt = CW'(dupNum);

    assign count  = count_q;
    assign full   = full_w;
    assign empty  = (count_q == '0);
    assign top    = (count_q >= CW'(1)) ? top_data : '0;
    assign second = (count_q >= CW'(2)) ? second_data : '0;

    // Decode the stack-control word; an illegal op raises its error event and changes nothing.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = pushData;
        swap_en = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (ESAct) begin
            if (flip) begin
                if (count_q >= CW'(2)) begin
                    swap_en = 1'b1;
                end else begin
                    unf_evt = 1'b1;
                end
            end else begin
                case (ESOp)
                    ES_PUSH: begin
                        if (full_w) begin
                            ovf_evt = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            ptr_d   = ptr_q + PW'(1);
                            count_d = count_q + CW'(1);
                        end
                    end
                    ES_POP: begin
                        if (count_q >= n_pop) begin
                            ptr_d   = ptr_q - n_ptr;
                            count_d = count_q - n_pop;
                        end else begin
                            unf_evt = 1'b1;
                        end
                    end
                    ES_DUP: begin
                        ovf_evt = full_w;
                        unf_evt = (count_q <= dup_cnt);
                        if (!full_w && (count_q > dup_cnt)) begin
                            wr_en   = 1'b1;
                            wr_data = dup_data;
                            ptr_d   = ptr_q + PW'(1);
                            count_d = count_q + CW'(1);
                        end
                    end
                    ES_REPL: begin
                        if (count_q >= n_pop) begin
                            wr_en   = 1'b1;
                            wr_addr = ptr_q - n_ptr;
                            ptr_d   = ptr_q - n_ptr + PW'(1);
                            count_d = count_q - CW'(popAmt);
                        end else begin
                            unf_evt = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

`ifdef EXPR_STACK_STATUS_EN
    logic ovf_q;
    logic unf_q;

    // Sticky error flags; a new error in the same cycle as errClr wins.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_evt | (ovf_q & ~errClr);
            unf_q <= unf_evt | (unf_q & ~errClr);
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    logic unused_status;
    assign unused_status = &{1'b0, errClr, ovf_evt, unf_evt};
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule
